// File: rtl/scatter_pkg.sv
// scatter_pkg: shared FP16 field constants, format enum and count-width helper for scatter_pipe
package scatter_pkg;
  typedef enum logic {FMT_FIXED = 1'b0, FMT_FP16 = 1'b1} format_e;
  localparam int FP16_SIGN = 15;
  localparam int FP16_EXP_HI = 14;
  localparam int FP16_EXP_LO = 10;
  localparam int FP16_MAN_HI = 9;
  localparam int FP16_MAN_LO = 0;
  localparam logic [15:0] FP16_MAG_MASK = ~(16'h1 << FP16_SIGN);
  function automatic int count_w(input int size);
    return $clog2(size + 1);
  endfunction
endpackage

// File: rtl/scatter_pipe_if.sv
// scatter_pipe_if: tile stream in, split planes plus mask/row status out, valid/ready on both sides
interface scatter_pipe_if import scatter_pkg::*; #(
  parameter int IN_WIDTH = 16,
  parameter int IN_SIZE = 4,
  parameter int IN_PARALLELISM = 1
);
  localparam int N = IN_SIZE * IN_PARALLELISM;
  localparam int CW = count_w(IN_SIZE);
  logic [N-1:0][IN_WIDTH-1:0] data_in, data_out_large, data_out_small;
  logic [N-1:0] outlier_mask;
  logic [IN_PARALLELISM-1:0][CW-1:0] row_count;
  logic [IN_PARALLELISM-1:0] row_overflow;
  logic data_in_valid, data_in_ready, data_out_valid, data_out_ready;
  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out_large, data_out_small, outlier_mask, row_count, row_overflow, data_out_valid
  );
  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out_large, data_out_small, outlier_mask, row_count, row_overflow, data_out_valid
  );
endinterface

// File: rtl/scatter_outlier_cmp.sv
// scatter_outlier_cmp: flags one element whose magnitude exceeds the threshold (FP16 NaN always flagged)
module scatter_outlier_cmp import scatter_pkg::*; #(
  parameter int IN_WIDTH = 16,
  parameter int FORMAT = 1
) (
  input  logic [IN_WIDTH-1:0] elem_i,
  input  logic [IN_WIDTH-1:0] thres_i,
  output logic                is_outlier_o
);
  logic [IN_WIDTH-1:0] mag;
  logic nan;
  if (FORMAT == int'(FMT_FP16)) begin : g_fp16
    assign mag = elem_i & FP16_MAG_MASK;
    assign nan = (&elem_i[FP16_EXP_HI:FP16_EXP_LO]) && (|elem_i[FP16_MAN_HI:FP16_MAN_LO]);
  end else begin : g_fixed
    // most-negative value has no positive twin, so it saturates to max positive
    assign mag = (elem_i == {1'b1, {(IN_WIDTH-1){1'b0}}}) ? {1'b0, {(IN_WIDTH-1){1'b1}}} :
                 elem_i[IN_WIDTH-1] ? -elem_i : elem_i;
    assign nan = 1'b0;
  end
  assign is_outlier_o = nan || (mag > thres_i);
endmodule

// File: rtl/scatter_pipe.sv
// scatter_pipe: two-stage back-pressured outlier splitter with row popcounts and saturating statistics
module scatter_pipe import scatter_pkg::*; #(
  parameter int IN_WIDTH = 16,
  parameter int IN_FRAC_WIDTH = 0,
  parameter int IN_SIZE = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int FORMAT = 1,
  parameter int LARGE_NUMBER_THRES = 127,
  parameter int MAX_OUTLIERS = 1,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  scatter_pipe_if.slave         bus,
  input  logic [IN_WIDTH-1:0]   thres_in,
  input  logic                  thres_load,
  input  logic                  stat_clear,
  output logic [STAT_WIDTH-1:0] outlier_total
);
  localparam int N = IN_SIZE * IN_PARALLELISM;
  localparam int CW = count_w(IN_SIZE);
  localparam int TW = count_w(N);
  if ((FORMAT == int'(FMT_FP16) && IN_WIDTH != 16) || IN_FRAC_WIDTH < 0 || IN_FRAC_WIDTH >= IN_WIDTH) begin : g_bad_params
    $error("scatter_pipe: unsupported IN_WIDTH/IN_FRAC_WIDTH/FORMAT combination");
  end
  logic [IN_WIDTH-1:0] thres_q;
  logic [N-1:0] mask_d, s1_mask_q, s2_mask_q;
  logic [N-1:0][IN_WIDTH-1:0] s1_data_q, large_d, small_d, large_q, small_q;
  logic [IN_PARALLELISM-1:0][CW-1:0] count_d, count_q;
  logic [IN_PARALLELISM-1:0] ovf_d, ovf_q;
  logic [TW-1:0] sum;
  logic [STAT_WIDTH:0] acc;
  logic [STAT_WIDTH-1:0] total_d, total_q;
  logic s1_valid_q, s2_valid_q, out_xfer, s1_adv, in_xfer;
  for (genvar i = 0; i < N; i++) begin : g_cmp
    scatter_outlier_cmp #(.IN_WIDTH(IN_WIDTH), .FORMAT(FORMAT)) u_cmp (
      .elem_i(bus.data_in[i]),
      .thres_i(thres_q),
      .is_outlier_o(mask_d[i])
    );
  end
  assign out_xfer = s2_valid_q && bus.data_out_ready;
  assign s1_adv = s1_valid_q && (!s2_valid_q || out_xfer);
  assign bus.data_in_ready = !rst && (!s1_valid_q || s1_adv);
  assign in_xfer = bus.data_in_valid && bus.data_in_ready;
  always_comb begin
    large_d = '0;
    small_d = '0;
    count_d = '0;
    ovf_d = '0;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      large_d[i] = s1_mask_q[i] ? s1_data_q[i] : '0;
      small_d[i] = s1_mask_q[i] ? '0 : s1_data_q[i];
    end
    for (int r = 0; r < IN_PARALLELISM; r++) begin
      for (int c = 0; c < IN_SIZE; c++) count_d[r] = count_d[r] + CW'(s1_mask_q[r*IN_SIZE + c]);
      ovf_d[r] = int'(count_d[r]) > MAX_OUTLIERS;
      sum = sum + TW'(count_q[r]);
    end
    acc = {1'b0, total_q} + (STAT_WIDTH+1)'(sum);
    total_d = stat_clear ? '0 : !out_xfer ? total_q : acc[STAT_WIDTH] ? '1 : acc[STAT_WIDTH-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thres_q <= IN_WIDTH'(LARGE_NUMBER_THRES);
      s1_valid_q <= 1'b0;
      s1_data_q <= '0;
      s1_mask_q <= '0;
      s2_valid_q <= 1'b0;
      large_q <= '0;
      small_q <= '0;
      s2_mask_q <= '0;
      count_q <= '0;
      ovf_q <= '0;
      total_q <= '0;
    end else begin
      if (thres_load) thres_q <= thres_in;
      if (bus.data_in_ready) s1_valid_q <= bus.data_in_valid;
      if (in_xfer) begin
        s1_data_q <= bus.data_in;
        s1_mask_q <= mask_d;
      end
      if (!s2_valid_q || out_xfer) s2_valid_q <= s1_valid_q;
      if (s1_adv) begin
        large_q <= large_d;
        small_q <= small_d;
        s2_mask_q <= s1_mask_q;
        count_q <= count_d;
        ovf_q <= ovf_d;
      end
      total_q <= total_d;
    end
  end
  assign bus.data_out_valid = s2_valid_q;
  assign bus.data_out_large = large_q;
  assign bus.data_out_small = small_q;
  assign bus.outlier_mask = s2_mask_q;
  assign bus.row_count = count_q;
  assign bus.row_overflow = ovf_q;
  assign outlier_total = total_q;
endmodule

// File: tb/tb_scatter_pipe.sv
// tb_scatter_pipe: directed checks of an FP16 two-row instance and an 8-bit fixed-point instance
module tb_scatter_pipe;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] thres_in_a, thres_in_f16;
  logic [7:0] thres_in_f;
  logic thres_load_a, stat_clear_a, thres_load_f, stat_clear_f;
  logic [3:0] total_a;
  logic [7:0] total_f;
  int vectors = 0;
  int errs = 0;
  int sent, recv, first_acc, first_val;
  logic stall;
  always #5 clk = ~clk;
  scatter_pipe_if #(.IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(2)) bus_a ();
  scatter_pipe_if #(.IN_WIDTH(8), .IN_SIZE(4), .IN_PARALLELISM(1)) bus_f ();
  scatter_pipe #(.IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(2), .FORMAT(1), .LARGE_NUMBER_THRES(16'h57F0),
                 .MAX_OUTLIERS(1), .STAT_WIDTH(4)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .thres_in(thres_in_a), .thres_load(thres_load_a),
    .stat_clear(stat_clear_a), .outlier_total(total_a));
  scatter_pipe #(.IN_WIDTH(8), .IN_SIZE(4), .IN_PARALLELISM(1), .FORMAT(0), .LARGE_NUMBER_THRES(5),
                 .MAX_OUTLIERS(1), .STAT_WIDTH(8)) u_f (
    .clk(clk), .rst(rst), .bus(bus_f.slave), .thres_in(thres_in_f), .thres_load(thres_load_f),
    .stat_clear(stat_clear_f), .outlier_total(total_f));
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] beat(input int k);
    beat = '0;
    for (int i = 0; i < 8; i++) beat[i*16 +: 16] = 16'h1000 + 16'(k*16 + i);
  endfunction
  task automatic push(input logic [127:0] d);
    bus_a.data_in = d;
    bus_a.data_in_valid = 1'b1;
    bus_a.data_out_ready = 1'b1;
    @(negedge clk);
    bus_a.data_in_valid = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    thres_in_a = '0; thres_in_f16 = '0; thres_in_f = '0;
    thres_load_a = 0; stat_clear_a = 0; thres_load_f = 0; stat_clear_f = 0;
    bus_a.data_in = '0; bus_a.data_in_valid = 0; bus_a.data_out_ready = 1;
    bus_f.data_in = '0; bus_f.data_in_valid = 0; bus_f.data_out_ready = 1;
    @(negedge clk);
    chk("rst_ready", bus_a.data_in_ready, 0);
    chk("rst_valid", bus_a.data_out_valid, 0);
    chk("rst_mask", bus_a.outlier_mask, 0);
    chk("rst_total", total_a, 0);
    chk("rst_ready_f", bus_f.data_in_ready, 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", bus_a.data_in_ready, 1);
    // boundary routing: row0 {57F0,5800,D800,3C00}, row1 {NaN,+Inf,-Inf,0001}
    push({16'h0001, 16'hFC00, 16'h7C00, 16'h7E00, 16'h3C00, 16'hD800, 16'h5800, 16'h57F0});
    chk("route_valid", bus_a.data_out_valid, 1);
    chk("route_mask", bus_a.outlier_mask, 8'h76);
    chk("route_large", bus_a.data_out_large, {16'h0, 16'hFC00, 16'h7C00, 16'h7E00, 16'h0, 16'hD800, 16'h5800, 16'h0});
    chk("route_small", bus_a.data_out_small, {16'h0001, 16'h0, 16'h0, 16'h0, 16'h3C00, 16'h0, 16'h0, 16'h57F0});
    chk("route_count", bus_a.row_count, {3'd3, 3'd2});
    chk("route_ovf", bus_a.row_overflow, 2'b11);
    @(negedge clk);
    chk("route_drained", bus_a.data_out_valid, 0);
    chk("route_total", total_a, 5);
    // fixed point: {-128,-5,6,5}
    bus_f.data_in = {8'd5, 8'd6, 8'hFB, 8'h80};
    bus_f.data_in_valid = 1;
    @(negedge clk);
    bus_f.data_in_valid = 0;
    @(negedge clk);
    chk("fx_valid", bus_f.data_out_valid, 1);
    chk("fx_mask", bus_f.outlier_mask, 4'b0101);
    chk("fx_count", bus_f.row_count, 3'd2);
    chk("fx_ovf", bus_f.row_overflow, 1'b1);
    chk("fx_large", bus_f.data_out_large, 32'h0006_0080);
    chk("fx_small", bus_f.data_out_small, 32'h0500_FB00);
    @(negedge clk);
    chk("fx_total", total_f, 2);
    // streaming with ready pattern 1,0,0,...
    sent = 0; recv = 0; first_acc = -1; first_val = -1; stall = 0;
    for (int c = 0; c < 60 && recv < 8; c++) begin
      bus_a.data_out_ready = (c % 3 == 0);
      bus_a.data_in_valid = sent < 8;
      bus_a.data_in = beat(sent);
      #1;
      if (stall) chk("stall_valid", bus_a.data_out_valid, 1);
      if (bus_a.data_out_valid) begin
        if (first_val < 0) first_val = c;
        chk("stream_order", bus_a.data_out_small, beat(recv));
        chk("stream_mask", bus_a.outlier_mask, 0);
        if (bus_a.data_out_ready) recv++;
      end
      if (bus_a.data_in_valid && bus_a.data_in_ready) begin
        if (first_acc < 0) first_acc = c;
        sent++;
      end
      stall = bus_a.data_out_valid && !bus_a.data_out_ready;
      @(negedge clk);
    end
    bus_a.data_in_valid = 0;
    bus_a.data_out_ready = 1;
    chk("stream_count", recv, 8);
    chk("stream_latency", first_val - first_acc, 2);
    // threshold reload in the same cycle beat A is accepted
    bus_a.data_in = 128'h5800;
    bus_a.data_in_valid = 1;
    thres_in_a = 16'h5BF8;
    thres_load_a = 1;
    @(negedge clk);
    thres_load_a = 0;
    @(negedge clk);
    bus_a.data_in_valid = 0;
    chk("reload_a_mask", bus_a.outlier_mask, 8'h01);
    chk("reload_a_large", bus_a.data_out_large, 128'h5800);
    chk("reload_a_ovf", bus_a.row_overflow, 2'b00);
    @(negedge clk);
    chk("reload_b_valid", bus_a.data_out_valid, 1);
    chk("reload_b_mask", bus_a.outlier_mask, 0);
    chk("reload_b_small", bus_a.data_out_small, 128'h5800);
    @(negedge clk);
    chk("reload_total", total_a, 6);
    // mid-stream async reset with two beats in flight
    bus_a.data_out_ready = 0;
    bus_a.data_in = 128'h1234;
    bus_a.data_in_valid = 1;
    @(negedge clk);
    @(negedge clk);
    bus_a.data_in_valid = 0;
    chk("inflight_valid", bus_a.data_out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", bus_a.data_out_valid, 0);
    chk("arst_ready", bus_a.data_in_ready, 0);
    chk("arst_total", total_a, 0);
    @(negedge clk);
    rst = 1'b0;
    bus_a.data_out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_stale", bus_a.data_out_valid, 0);
    end
    push(128'h5800);
    chk("thres_default", bus_a.outlier_mask, 8'h01);
    @(negedge clk);
    chk("post_rst_total", total_a, 1);
    // statistics
    stat_clear_a = 1;
    @(negedge clk);
    stat_clear_a = 0;
    chk("clear_total", total_a, 0);
    push(128'h5800_5800);
    chk("stat_cnt2", bus_a.row_count, {3'd0, 3'd2});
    @(negedge clk);
    chk("stat_total2", total_a, 2);
    push(128'h0);
    @(negedge clk);
    chk("stat_total2b", total_a, 2);
    push({64'h5800_5800_5800_5800, 64'h0});
    chk("stat_cnt4", bus_a.row_count, {3'd4, 3'd0});
    chk("stat_ovf4", bus_a.row_overflow, 2'b10);
    @(negedge clk);
    chk("stat_total6", total_a, 6);
    push(128'h5800_5800);
    stat_clear_a = 1;
    @(negedge clk);
    stat_clear_a = 0;
    chk("clear_wins", total_a, 0);
    push({8{16'h5800}});
    @(negedge clk);
    chk("sat_pre", total_a, 8);
    push({8{16'h5800}});
    @(negedge clk);
    chk("sat_hit", total_a, 15);
    push({8{16'h5800}});
    @(negedge clk);
    chk("sat_hold", total_a, 15);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
